main_ctrl_fsm: RTL and testbench
================================

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26], held stable by IR between fetches.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake, access completes in any cycle it is high.
REQ-005 SHALL have ports: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
REQ-006 SHALL have ports: alu_src_b  output  2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2); pc_source  output  2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 SHALL have port: alu_op  output  3  ALU-control code: 000 add, 001 sub-imm, 010 R-type funct, 101 branch compare (sub).
REQ-008 SHALL have ports: illegal  output  1  one-cycle flag; state  output  4  current state for debug.

Function
REQ-009 SHALL be a Moore FSM, except ir_write/pc_write in FETCH and transitions gated by mem_ready, plus illegal in DECODE.
REQ-010 Opcodes SHALL be: R 0, J 2, BEQ 4, ADDI 8, SUBI 9, LW 35, SW 43; anything else illegal.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000; when mem_ready: ir_write=1, pc_write=1, next DECODE; else stay.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; next by opcode: R->EXEC_R, ADDI/SUBI->EXEC_I, LW/SW->MEM_ADDR, BEQ->BRANCH, J->JUMP, illegal->FETCH with illegal=1 this cycle.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD (LW) or MEM_WR (SW).
REQ-014 MEM_RD: mem_read=1, i_or_d=1; mem_ready -> WB_MEM, else stay. WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-015 MEM_WR: mem_write=1, i_or_d=1; mem_ready -> FETCH, else stay.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010; next WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-017 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000 (ADDI) or 001 (SUBI); next WB_I: reg_write=1, reg_dst=0; next FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=101, pc_write_cond=1, pc_source=01; next FETCH.
REQ-019 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-020 Every output not listed for a state SHALL be 0; state output SHALL equal the encoded current state.
REQ-021 Latency with mem_ready constantly high: LW 5, SW/R/ADDI/SUBI 4, BEQ/J 3 cycles; each low mem_ready cycle adds one.

Reset
REQ-022 rst high at a clock edge SHALL force FETCH, from any state including mid memory wait.
REQ-023 While rst is high all outputs SHALL be 0 (ir_write/pc_write suppressed even if mem_ready high); state=0 (FETCH).

Configuration
REQ-024 Macro MAIN_CTRL_JUMP_EN: defined -> opcode 2 decodes to JUMP per REQ-019; undefined -> JUMP state absent, opcode 2 illegal per REQ-012.

Structure
REQ-025 Package mips_ctrl_pkg SHALL hold opcode constants, alu_op codes, alu_src_b/pc_source encodings and the state enum (FETCH=0..JUMP=11).
REQ-026 Output decode SHALL be a combinational sub-module ctrl_out_dec (state, opcode, mem_ready, rst -> outputs); state register and next-state in main_ctrl_fsm.

Verification
REQ-027 rst 2 cycles, release, mem_ready=1, opcode=35 -> states 0,1,3,4,5(WB_MEM) then 0; reg_write=1, mem_to_reg=1 only in WB_MEM.
REQ-028 opcode=0, mem_ready=1 -> alu_op=010 in EXEC_R, reg_dst=1 reg_write=1 next cycle, back to FETCH after 4 cycles.
REQ-029 opcode=9 -> alu_op=001 in EXEC_I; opcode=4 -> alu_op=101, pc_write_cond=1, 3-cycle instruction.
REQ-030 opcode=43, mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, FETCH after mem_ready rises; FETCH with mem_ready low -> ir_write=0 stays.
REQ-031 opcode=63 -> illegal=1 for exactly the DECODE cycle, next FETCH; opcode=2 with/without MAIN_CTRL_JUMP_EN -> JUMP (pc_source=10) / illegal.
REQ-032 rst asserted during MEM_RD wait -> next state FETCH, all outputs 0 while rst high.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, ALU-control, mux-select and state encodings shared by the
// multicycle main controller. MAIN_CTRL_JUMP_EN selects whether opcode 2 is legal.
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SUBI = 6'd9;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUBI  = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b101;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MAIN_CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // Numbering places MEM_WR at 2 so a load walks through 0,1,3,4,5.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_WR   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    WB_MEM   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_R, OP_BEQ, OP_ADDI, OP_SUBI, OP_LW, OP_SW: legal = 1'b1;
      OP_J:                                         legal = JUMP_EN;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_out_dec.sv
// ctrl_out_dec: combinational output decode for the main controller; every output
// is forced low while rst is high.
`default_nettype none

module ctrl_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t      cur_state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        rst,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    state         = 4'd0;
    if (!rst) begin
      state = cur_state;
      case (cur_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          illegal   = !opcode_legal(opcode);
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (opcode == OP_SUBI) ? ALU_SUBI : ALU_ADD;
        end
        WB_I: begin
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_BR;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multicycle MIPS main controller (state register + next state).
// Build option MAIN_CTRL_JUMP_EN enables the J instruction (opcode 2).
`default_nettype none

module main_ctrl_fsm
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t cur_state;
  state_t nxt_state;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      FETCH:    if (mem_ready) nxt_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:             nxt_state = EXEC_R;
          OP_ADDI, OP_SUBI: nxt_state = EXEC_I;
          OP_LW, OP_SW:     nxt_state = MEM_ADDR;
          OP_BEQ:           nxt_state = BRANCH;
          OP_J:             nxt_state = JUMP_EN ? JUMP : FETCH;
          default:          nxt_state = FETCH;
        endcase
      end
      MEM_ADDR: nxt_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) nxt_state = WB_MEM;
      MEM_WR:   if (mem_ready) nxt_state = FETCH;
      EXEC_R:   nxt_state = WB_R;
      EXEC_I:   nxt_state = WB_I;
      default:  nxt_state = FETCH;
    endcase
  end

  ctrl_out_dec u_dec (
    .cur_state     (cur_state),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .rst           (rst),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal       (illegal),
    .state         (state)
  );

endmodule

`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
// tb_main_ctrl_fsm: directed-vector scoreboard bench for main_ctrl_fsm.
`default_nettype none

module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  main_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {state, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluop, ill}
  logic [21:0] act;
  assign act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal};

  localparam logic [21:0] E_ZERO     = {4'd0,  10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_FETCH_W  = {4'd0,  10'b0001000000, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_FETCH_GO = {4'd0,  10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_DECODE   = {4'd1,  10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_DEC_ILL  = {4'd1,  10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b1};
  localparam logic [21:0] E_MEMWR    = {4'd2,  10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_MEMADDR  = {4'd3,  10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_MEMRD    = {4'd4,  10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_WBMEM    = {4'd5,  10'b0000001010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_EXECR    = {4'd6,  10'b0000000001, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [21:0] E_WBR      = {4'd7,  10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_EXECI_A  = {4'd8,  10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_EXECI_S  = {4'd8,  10'b0000000001, 2'b10, 2'b00, 3'b001, 1'b0};
  localparam logic [21:0] E_WBI      = {4'd9,  10'b0000000010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [21:0] E_BRANCH   = {4'd10, 10'b0100000001, 2'b00, 2'b01, 3'b101, 1'b0};
  localparam logic [21:0] E_JUMP     = {4'd11, 10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b0};

  logic [21:0] sb_exp[$];
  string       sb_name[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    if (sb_exp.size() > 0) begin
      logic [21:0] e;
      string       nm;
      e  = sb_exp.pop_front();
      nm = sb_name.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (state got %0d exp %0d)", nm, act, e, state, e[21:18]);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [21:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = mr;
    sb_exp.push_back(e);
    sb_name.push_back(nm);
  endtask

  initial begin
    // reset, with mem_ready high to show strobes stay suppressed
    step(1, 6'd35, 1, E_ZERO, "rst_c0");
    step(1, 6'd35, 1, E_ZERO, "rst_c1");
    // LW, memory always ready
    step(0, 6'd35, 1, E_FETCH_GO, "lw_fetch");
    step(0, 6'd35, 1, E_DECODE,   "lw_decode");
    step(0, 6'd35, 1, E_MEMADDR,  "lw_memaddr");
    step(0, 6'd35, 1, E_MEMRD,    "lw_memrd");
    step(0, 6'd35, 1, E_WBMEM,    "lw_wbmem");
    // R-type
    step(0, 6'd0, 1, E_FETCH_GO, "r_fetch");
    step(0, 6'd0, 1, E_DECODE,   "r_decode");
    step(0, 6'd0, 1, E_EXECR,    "r_exec");
    step(0, 6'd0, 1, E_WBR,      "r_wb");
    // SUBI and ADDI
    step(0, 6'd9, 1, E_FETCH_GO, "subi_fetch");
    step(0, 6'd9, 1, E_DECODE,   "subi_decode");
    step(0, 6'd9, 1, E_EXECI_S,  "subi_exec");
    step(0, 6'd9, 1, E_WBI,      "subi_wb");
    step(0, 6'd8, 1, E_FETCH_GO, "addi_fetch");
    step(0, 6'd8, 1, E_DECODE,   "addi_decode");
    step(0, 6'd8, 1, E_EXECI_A,  "addi_exec");
    step(0, 6'd8, 1, E_WBI,      "addi_wb");
    // BEQ
    step(0, 6'd4, 1, E_FETCH_GO, "beq_fetch");
    step(0, 6'd4, 1, E_DECODE,   "beq_decode");
    step(0, 6'd4, 1, E_BRANCH,   "beq_branch");
    // SW with three wait cycles, then a stalled fetch
    step(0, 6'd43, 1, E_FETCH_GO, "sw_fetch");
    step(0, 6'd43, 1, E_DECODE,   "sw_decode");
    step(0, 6'd43, 1, E_MEMADDR,  "sw_memaddr");
    step(0, 6'd43, 0, E_MEMWR,    "sw_wait0");
    step(0, 6'd43, 0, E_MEMWR,    "sw_wait1");
    step(0, 6'd43, 0, E_MEMWR,    "sw_wait2");
    step(0, 6'd43, 1, E_MEMWR,    "sw_done");
    step(0, 6'd63, 0, E_FETCH_W,  "fetch_stall0");
    step(0, 6'd63, 0, E_FETCH_W,  "fetch_stall1");
    // illegal opcode
    step(0, 6'd63, 1, E_FETCH_GO, "ill_fetch");
    step(0, 6'd63, 1, E_DEC_ILL,  "ill_decode");
    // opcode 2: jump or illegal depending on build
    step(0, 6'd2, 1, E_FETCH_GO, "j_fetch");
`ifdef MAIN_CTRL_JUMP_EN
    step(0, 6'd2, 1, E_DECODE,   "j_decode");
    step(0, 6'd2, 1, E_JUMP,     "j_jump");
`else
    step(0, 6'd2, 1, E_DEC_ILL,  "j_decode_ill");
`endif
    // reset during a load's memory wait
    step(0, 6'd35, 1, E_FETCH_GO, "lwr_fetch");
    step(0, 6'd35, 1, E_DECODE,   "lwr_decode");
    step(0, 6'd35, 1, E_MEMADDR,  "lwr_memaddr");
    step(0, 6'd35, 0, E_MEMRD,    "lwr_wait");
    step(1, 6'd35, 1, E_ZERO,     "lwr_rst0");
    step(1, 6'd35, 1, E_ZERO,     "lwr_rst1");
    step(0, 6'd35, 1, E_FETCH_GO, "lwr_refetch");
    step(0, 6'd35, 1, E_DECODE,   "lwr_redecode");

    for (int i = 0; i < 20 && sb_exp.size() > 0; i++) @(posedge clk);
    if (sb_exp.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
